// File: rtl/disp_timing_pkg.sv
// Shared display constants for the VGA raster generator and the pixel/colour
// controllers that consume its hCount/vCount/bright bus.
// Contents: default 640x480@60 timing constants, counter width, 12-bit RGB
// colour constants, and a small inclusive-range helper.
package disp_timing_pkg;

    localparam int unsigned DEF_CLK_DIV      = 4;
    localparam int unsigned DEF_H_TOTAL      = 800;
    localparam int unsigned DEF_H_SYNC       = 96;
    localparam int unsigned DEF_H_DISP_START = 144;
    localparam int unsigned DEF_H_DISP_END   = 783;
    localparam int unsigned DEF_V_TOTAL      = 525;
    localparam int unsigned DEF_V_SYNC       = 2;
    localparam int unsigned DEF_V_DISP_START = 35;
    localparam int unsigned DEF_V_DISP_END   = 514;

    localparam int unsigned CNT_W = 10;

    typedef logic [11:0] rgb_t;

    localparam rgb_t RED       = 12'hF00;
    localparam rgb_t YELLOW    = 12'hFF0;
    localparam rgb_t BG_COLOUR = 12'h000;

    function automatic logic in_range(input logic [CNT_W-1:0] x,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: counts system clocks 0..CLK_DIV-1 and flags the last
// count, which is the cycle on which the raster counters advance.
// Ports:
//   clk   - system clock
//   rst   - synchronous, active-high reset (divider restarts at 0)
//   o_adv - high during the clock whose rising edge advances the raster
module pix_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_adv
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be >= 2");
    end

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_adv = (r_div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60 from a 100 MHz clock).
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   hCount, vCount    - 10-bit raster position
//   bright            - position is inside the visible window
//   hSync, vSync      - active-low sync pulses
//   pix_tick          - one-clk pulse in the cycle after the counters advance
//   frame_tick        - pix_tick on which the counters become (0,0)
//   frame_count       - 16-bit wrapping frame counter, only present when the
//                       DISP_FRAME_CNT_EN macro is defined
module vga_timing_gen
    import disp_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_DISP_START = DEF_H_DISP_START,
    parameter int unsigned H_DISP_END   = DEF_H_DISP_END,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_DISP_START = DEF_V_DISP_START,
    parameter int unsigned V_DISP_END   = DEF_V_DISP_END
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             bright,
    output logic             hSync,
    output logic             vSync,
    output logic             pix_tick,
    output logic             frame_tick
`ifdef DISP_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("H_TOTAL and V_TOTAL must be <= 1024");
    end

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_DS_C  = CNT_W'(H_DISP_START);
    localparam logic [CNT_W-1:0] H_DE_C  = CNT_W'(H_DISP_END);
    localparam logic [CNT_W-1:0] V_DS_C  = CNT_W'(V_DISP_START);
    localparam logic [CNT_W-1:0] V_DE_C  = CNT_W'(V_DISP_END);

    logic w_adv;

    pix_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .o_adv(w_adv)
    );

    logic [CNT_W-1:0] r_h_count;
    logic [CNT_W-1:0] r_v_count;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_frame_wrap;
    logic             r_bright;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_pix_tick;
    logic             r_frame_tick;

    always_comb begin
        w_h_next     = r_h_count;
        w_v_next     = r_v_count;
        w_frame_wrap = 1'b0;
        if (w_adv) begin
            if (r_h_count == H_LAST) begin
                w_h_next = '0;
                if (r_v_count == V_LAST) begin
                    w_v_next     = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_v_next = r_v_count + 1'b1;
                end
            end else begin
                w_h_next = r_h_count + 1'b1;
            end
        end
    end

    // Sync/bright are decoded from the next-state counts so they land in the
    // same cycle as the counter values they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_count    <= '0;
            r_v_count    <= '0;
            r_bright     <= 1'b0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_pix_tick   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_h_count    <= w_h_next;
            r_v_count    <= w_v_next;
            r_hsync      <= (w_h_next >= H_SYNC_C);
            r_vsync      <= (w_v_next >= V_SYNC_C);
            r_bright     <= in_range(w_h_next, H_DS_C, H_DE_C) &&
                            in_range(w_v_next, V_DS_C, V_DE_C);
            r_pix_tick   <= w_adv;
            r_frame_tick <= w_frame_wrap;
        end
    end

`ifdef DISP_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_count = r_frame_cnt;
`endif

    assign hCount     = r_h_count;
    assign vCount     = r_v_count;
    assign bright     = r_bright;
    assign hSync      = r_hsync;
    assign vSync      = r_vsync;
    assign pix_tick   = r_pix_tick;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance driven through reset,
// two lines and a mid-line reset, plus a shrunken-timing instance hit with
// random run lengths and reset pulses so whole frames fit in the run.
// Expected outputs come from the clock count since reset via plain arithmetic.
module tb_vga_timing_gen;

    localparam longint D_CD = 4,  D_HT = 800, D_HS = 96, D_HDS = 144, D_HDE = 783;
    localparam longint D_VT = 525, D_VS = 2,  D_VDS = 35, D_VDE = 514;
    localparam longint S_CD = 2,  S_HT = 20,  S_HS = 3,  S_HDS = 5,   S_HDE = 16;
    localparam longint S_VT = 12, S_VS = 2,   S_VDS = 3, S_VDE = 9;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        br;
        logic        hs;
        logic        vs;
        logic        pt;
        logic        ft;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_d = 1'b0;
    logic rst_s = 1'b0;

    logic [9:0]  hc_d, vc_d, hc_s, vc_s;
    logic        br_d, hs_d, vs_d, pt_d, ft_d;
    logic        br_s, hs_s, vs_s, pt_s, ft_s;
    logic [15:0] fc_d, fc_s;

    int n_cmp = 0;
    int n_bad = 0;

    longint n_d = 0, n_s = 0;
    logic   started_d = 1'b0, started_s = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_def (
        .clk        (clk),
        .rst        (rst_d),
        .hCount     (hc_d),
        .vCount     (vc_d),
        .bright     (br_d),
        .hSync      (hs_d),
        .vSync      (vs_d),
        .pix_tick   (pt_d),
        .frame_tick (ft_d)
`ifdef DISP_FRAME_CNT_EN
        ,
        .frame_count(fc_d)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV     (2),
        .H_TOTAL     (20),
        .H_SYNC      (3),
        .H_DISP_START(5),
        .H_DISP_END  (16),
        .V_TOTAL     (12),
        .V_SYNC      (2),
        .V_DISP_START(3),
        .V_DISP_END  (9)
    ) u_dut_small (
        .clk        (clk),
        .rst        (rst_s),
        .hCount     (hc_s),
        .vCount     (vc_s),
        .bright     (br_s),
        .hSync      (hs_s),
        .vSync      (vs_s),
        .pix_tick   (pt_s),
        .frame_tick (ft_s)
`ifdef DISP_FRAME_CNT_EN
        ,
        .frame_count(fc_s)
`endif
    );

`ifndef DISP_FRAME_CNT_EN
    assign fc_d = '0;
    assign fc_s = '0;
`endif

    // n = rising edges since the last reset edge; everything follows from it.
    function automatic exp_t model(input longint n, input longint cd, input longint ht,
                                   input longint hsw, input longint hds, input longint hde,
                                   input longint vt, input longint vsw, input longint vds,
                                   input longint vde);
        exp_t   m;
        longint k, fr, p, h, v;
        k = n / cd;
        fr = ht * vt;
        p = k % fr;
        h = p % ht;
        v = p / ht;
        m.h  = 10'(h);
        m.v  = 10'(v);
        m.hs = (h >= hsw);
        m.vs = (v >= vsw);
        m.br = (h >= hds) && (h <= hde) && (v >= vds) && (v <= vde);
        m.pt = (n > 0) && ((n % cd) == 0);
        m.ft = m.pt && (p == 0);
`ifdef DISP_FRAME_CNT_EN
        m.fc = 16'((k / fr) % 65536);
`else
        m.fc = '0;
`endif
        return m;
    endfunction

    task automatic cmp(input string name, input longint n, input exp_t act, input exp_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s n=%0d actual h=%0d v=%0d br=%b hs=%b vs=%b pt=%b ft=%b fc=%0d required h=%0d v=%0d br=%b hs=%b vs=%b pt=%b ft=%b fc=%0d",
                     name, n, act.h, act.v, act.br, act.hs, act.vs, act.pt, act.ft, act.fc,
                     req.h, req.v, req.br, req.hs, req.vs, req.pt, req.ft, req.fc);
        end
    endtask

    task automatic lit(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        n_d       <= rst_d ? 64'd0 : n_d + 1;
        n_s       <= rst_s ? 64'd0 : n_s + 1;
        started_d <= started_d | rst_d;
        started_s <= started_s | rst_s;
    end

    exp_t act_d, act_s;
    assign act_d = {hc_d, vc_d, br_d, hs_d, vs_d, pt_d, ft_d, fc_d};
    assign act_s = {hc_s, vc_s, br_s, hs_s, vs_s, pt_s, ft_s, fc_s};

    always @(negedge clk) begin
        if (started_d) begin
            cmp("def", n_d, act_d, model(n_d, D_CD, D_HT, D_HS, D_HDS, D_HDE,
                                         D_VT, D_VS, D_VDS, D_VDE));
            if (n_d == 0) lit("def_reset_state", int'(act_d), 0);
            if (n_d == 3) lit("def_no_tick_yet", int'(pt_d), 0);
            if (n_d == 4) begin
                lit("def_first_tick_pt", int'(pt_d), 1);
                lit("def_first_tick_h", int'(hc_d), 1);
            end
            if (n_d == 380) begin
                lit("def_h95", int'(hc_d), 95);
                lit("def_hsync_at_95", int'(hs_d), 0);
            end
            if (n_d == 384) lit("def_hsync_at_96", int'(hs_d), 1);
            if (n_d == 3199) lit("def_h799", int'(hc_d), 799);
            if (n_d == 3200) begin
                lit("def_wrap_h", int'(hc_d), 0);
                lit("def_wrap_v", int'(vc_d), 1);
            end
            if (n_d == 4800) lit("def_pre_reset_h", int'(hc_d), 400);
        end
        if (started_s) begin
            cmp("small", n_s, act_s, model(n_s, S_CD, S_HT, S_HS, S_HDS, S_HDE,
                                           S_VT, S_VS, S_VDS, S_VDE));
            if (n_s == 479) begin
                lit("small_last_v", int'(vc_s), 11);
                lit("small_last_ft", int'(ft_s), 0);
            end
            if (n_s == 480) begin
                lit("small_frame_ft", int'(ft_s), 1);
                lit("small_frame_pt", int'(pt_s), 1);
                lit("small_frame_hv", int'({hc_s, vc_s}), 0);
            end
        end
    end

    initial begin
        fork
            begin
                @(posedge clk);
                #2 rst_d = 1'b1;
                repeat (3) @(posedge clk);
                #2 rst_d = 1'b0;
                repeat (4800) @(posedge clk);
                #2 rst_d = 1'b1;
                @(posedge clk);
                #2 rst_d = 1'b0;
                repeat (4000) @(posedge clk);
            end
            begin
                @(posedge clk);
                #2 rst_s = 1'b1;
                repeat (2) @(posedge clk);
                #2 rst_s = 1'b0;
                repeat (1500) @(posedge clk);
                for (int i = 0; i < 40; i++) begin
                    #2 rst_s = 1'b1;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #2 rst_s = 1'b0;
                    repeat ($urandom_range(1, 1500)) @(posedge clk);
                end
            end
        join
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
